// File: rtl/uart_reg_bridge.sv
// Bus-side front end for the UART register block: turns one valid/ready request
// into a single reg_we/reg_re strobe and returns a registered response.
module uart_reg_bridge #(
  parameter int unsigned   AW        = 12,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] MAX_ADDR  = 12'h01C,
  parameter logic [DW-1:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  input  logic [3:0]    req_be_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          reg_we_o,
  output logic          reg_re_o,
  output logic [AW-1:0] reg_addr_o,
  output logic [DW-1:0] reg_wdata_o,
  input  logic [DW-1:0] reg_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, RESP} state_e;

  state_e state_q, state_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          reg_we_q, reg_we_d;
  logic          reg_re_q, reg_re_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [DW-1:0] reg_wdata_q, reg_wdata_d;

  logic accept;
  logic acc_err;

  // Reads ignore byte enables; writes must be full-word.
  always_comb begin
    accept  = req_valid_i && req_ready_q;
    acc_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i > MAX_ADDR) ||
              (req_write_i && (req_be_i != 4'hF));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_err)          state_d = RESP;
          else if (req_write_i) state_d = WR;
          else                  state_d = RD;
        end
      end
      WR:      state_d = RESP;
      RD:      state_d = RD_CAP;
      RD_CAP:  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so each is decoded from the state being entered.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    reg_we_d    = (state_d == WR);
    reg_re_d    = (state_d == RD);
    rsp_valid_d = (state_d == RESP);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    if (accept) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = acc_err ? ERR_RDATA : '0;
      if (!acc_err) begin
        reg_addr_d  = req_addr_i;
        reg_wdata_d = req_wdata_i;
      end
    end
    if (state_q == RD_CAP) rsp_rdata_d = reg_rdata_i;
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign reg_we_o    = reg_we_q;
  assign reg_re_o    = reg_re_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed self-checking bench for uart_reg_bridge; the read-data model answers
// the cycle after reg_re_o and drives junk at every other time.
module tb_uart_reg_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, reg_we_o, reg_re_o;
  logic [11:0] reg_addr_o;
  logic [31:0] reg_wdata_o, reg_rdata_i;

  int n_cmp = 0;
  int n_err = 0;

  int          we_cnt = 0, re_cnt = 0, both_cnt = 0, adj_cnt = 0;
  logic        prev_strobe = 1'b0;
  logic [11:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;

  logic [31:0] rd_model;
  logic        re_prev;

  uart_reg_bridge #(
    .AW(12), .DW(32), .MAX_ADDR(12'h01C), .ERR_RDATA(32'h0000_0000)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (reg_we_o) begin
      we_cnt++;
      last_we_addr = reg_addr_o;
      last_we_data = reg_wdata_o;
    end
    if (reg_re_o) re_cnt++;
    if (reg_we_o && reg_re_o) both_cnt++;
    if ((reg_we_o || reg_re_o) && prev_strobe) adj_cnt++;
    prev_strobe = reg_we_o || reg_re_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    reg_rdata_i = re_prev ? rd_model : 32'hDEAD_BEEF;
    re_prev     = reg_re_o;
  endtask

  // One transaction with rsp_ready_i high; lat counts cycles from accept to rsp_valid_o.
  task automatic txn(input string tag, input logic wr, input logic [11:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input logic [31:0] model,
                     input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int we0, re0, lat;
    we0 = we_cnt;
    re0 = re_cnt;
    chk({tag, ".ready"}, {31'b0, req_ready_o}, 32'd1);
    rd_model    = model;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_be_i    = be;
    tick();
    req_valid_i = 1'b0;
    req_addr_i  = 12'hFFF;
    req_wdata_i = 32'h5555_AAAA;
    lat = 1;
    while (!rsp_valid_o && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".err"}, {31'b0, rsp_err_o}, {31'b0, exp_err});
    chk({tag, ".rdata"}, rsp_rdata_o, exp_rd);
    tick();
    chk({tag, ".vdrop"}, {31'b0, rsp_valid_o}, 32'd0);
    chk({tag, ".nwe"}, we_cnt - we0, (wr && !exp_err) ? 1 : 0);
    chk({tag, ".nre"}, re_cnt - re0, (!wr && !exp_err) ? 1 : 0);
  endtask

  initial begin
    int we0, re0;
    longint t0;
    logic [31:0] b2b [4];
    b2b = '{32'h11, 32'h22, 32'h33, 32'h44};

    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_be_i = '0; rsp_ready_i = 1'b1; reg_rdata_i = 32'hDEAD_BEEF;
    rd_model = '0; re_prev = 1'b0;

    #12;
    chk("rst.ready", {31'b0, req_ready_o}, 32'd0);
    chk("rst.valid", {31'b0, rsp_valid_o}, 32'd0);
    chk("rst.rdata", rsp_rdata_o, 32'd0);
    chk("rst.err", {31'b0, rsp_err_o}, 32'd0);
    chk("rst.strobes", {30'b0, reg_we_o, reg_re_o}, 32'd0);
    chk("rst.addr", {20'b0, reg_addr_o}, 32'd0);
    chk("rst.wdata", reg_wdata_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    #1 chk("rel.ready0", {31'b0, req_ready_o}, 32'd0);
    tick();
    chk("rel.ready1", {31'b0, req_ready_o}, 32'd1);

    txn("wr0", 1'b1, 12'h000, 32'h0000_0364, 4'hF, 32'h0, 1'b0, 32'h0, 2);
    chk("wr0.addr", {20'b0, last_we_addr}, 32'h000);
    chk("wr0.data", last_we_data, 32'h0000_0364);

    txn("rd8", 1'b0, 12'h008, 32'h0, 4'h0, 32'h0000_00A5, 1'b0, 32'h0000_00A5, 3);
    chk("rd8.addr", {20'b0, reg_addr_o}, 32'h008);
    txn("rdmax", 1'b0, 12'h01C, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 32'h1234_5678, 3);

    txn("e.mis", 1'b1, 12'h006, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 32'h0, 1);
    txn("e.oor", 1'b0, 12'h020, 32'h0, 4'hF, 32'h7777_7777, 1'b1, 32'h0, 1);
    txn("e.be", 1'b1, 12'h004, 32'h0000_0099, 4'h1, 32'h0, 1'b1, 32'h0, 1);

    // Response stall with a competing request held on the input.
    we0 = we_cnt;
    rsp_ready_i = 1'b0;
    rd_model = 32'h0000_5A5A;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 12'h010; req_be_i = 4'hF;
    tick();
    req_valid_i = 1'b0;
    chk("st.re", {31'b0, reg_re_o}, 32'd1);
    tick();
    tick();
    chk("st.valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("st.rdata", rsp_rdata_o, 32'h0000_5A5A);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 12'h00C;
    req_wdata_i = 32'h0000_CAFE; req_be_i = 4'hF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st.hvalid", {31'b0, rsp_valid_o}, 32'd1);
      chk("st.hrdata", rsp_rdata_o, 32'h0000_5A5A);
      chk("st.herr", {31'b0, rsp_err_o}, 32'd0);
      chk("st.hready", {31'b0, req_ready_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    tick();
    chk("st.vdrop", {31'b0, rsp_valid_o}, 32'd0);
    chk("st.ready", {31'b0, req_ready_o}, 32'd1);
    chk("st.nowe", we_cnt - we0, 0);
    tick();
    req_valid_i = 1'b0;
    chk("st.we", {31'b0, reg_we_o}, 32'd1);
    chk("st.weaddr", {20'b0, reg_addr_o}, 32'h00C);
    chk("st.wedata", reg_wdata_o, 32'h0000_CAFE);
    tick();
    chk("st.wvalid", {31'b0, rsp_valid_o}, 32'd1);
    chk("st.wrdata", rsp_rdata_o, 32'd0);
    tick();
    chk("st.wready", {31'b0, req_ready_o}, 32'd1);

    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      txn("b2b", 1'b1, 12'h004, b2b[i], 4'hF, 32'h0, 1'b0, 32'h0, 2);
      chk("b2b.data", last_we_data, b2b[i]);
      chk("b2b.addr", {20'b0, last_we_addr}, 32'h004);
    end
    chk("b2b.time", 32'($time - t0), 32'd120);

    // Reset in the middle of a read.
    re0 = re_cnt;
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 12'h014; req_be_i = 4'hF;
    tick();
    req_valid_i = 1'b0;
    chk("rr.re", {31'b0, reg_re_o}, 32'd1);
    #1 rst_ni = 1'b0;
    #1 chk("rr.redrop", {31'b0, reg_re_o}, 32'd0);
    chk("rr.ready", {31'b0, req_ready_o}, 32'd0);
    tick();
    tick();
    chk("rr.novalid", {31'b0, rsp_valid_o}, 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("rr.ready1", {31'b0, req_ready_o}, 32'd1);
    chk("rr.novalid2", {31'b0, rsp_valid_o}, 32'd0);
    chk("rr.nre", re_cnt - re0, 1);

    chk("mon.both", both_cnt, 0);
    chk("mon.adjacent", adj_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_reg_bridge.md
Name: uart_reg_bridge

Overview:
- Bus-side front end for the UART register block: accepts one-at-a-time valid/ready requests from the SoC interconnect and converts each into exactly one single-cycle reg_we or reg_re strobe on the UART register interface.
- Captures registered read data and returns a response over a valid/ready channel.
- Rejects misaligned, partial-width and out-of-range accesses with an error response, without touching the UART, so stray accesses never push the TX FIFO or pop the RX FIFO.

Parameters:
- AW, 12, register address width
- DW, 32, data width
- MAX_ADDR, 12'h01C, highest mapped word address
- ERR_RDATA, 32'h0000_0000, rdata returned on error responses

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid&&ready
- req_write_i  input  1  1=write, 0=read
- req_addr_i  input  AW  byte address
- req_wdata_i  input  DW  write data
- req_be_i  input  4  byte enables
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed when valid&&ready
- rsp_rdata_o  output  DW  read data (0 for writes)
- rsp_err_o  output  1  access error
- reg_we_o  output  1  UART register write strobe
- reg_re_o  output  1  UART register read strobe
- reg_addr_o  output  AW  UART register address
- reg_wdata_o  output  DW  UART register write data
- reg_rdata_i  input  DW  UART read data; registered, valid the cycle after reg_re_o

Behaviour:
- Reset (async, rst_ni low): state=IDLE, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, reg_we_o=0, reg_re_o=0, reg_addr_o=0, reg_wdata_o=0. All outputs are registered.
- req_ready_o=1 only in IDLE. It goes high the first clock after reset release.
- FSM states: IDLE, WR, RD, RD_CAP, RESP.
- IDLE, on accept: latch write, addr, wdata, be. Error is set if any of the following holds: addr[1:0]!=0; addr>MAX_ADDR; write with be!=4'hF. Reads ignore be. Next state is RESP on error; otherwise WR for a write, RD for a read.
- WR: reg_we_o=1 for exactly this one cycle, with reg_addr_o and reg_wdata_o valid. Next state RESP. rsp_valid_o rises the cycle after the reg_we_o pulse, with rsp_err_o=0 and rsp_rdata_o=0.
- RD: reg_re_o=1 for exactly this one cycle. Next state RD_CAP.
- RD_CAP: capture reg_rdata_i into rsp_rdata_o. Next state RESP.
- Read latency: accept edge -> reg_re_o the next cycle -> rsp_valid_o 3 cycles after accept.
- RESP: rsp_valid_o=1 and rsp_rdata_o/rsp_err_o are held stable until rsp_ready_i. On that handshake edge, rsp_valid_o drops and state returns to IDLE. req_ready_o is high the following cycle, so at most one transaction is outstanding.
- Error path: reg_we_o and reg_re_o stay 0. rsp_err_o=1, rsp_rdata_o=ERR_RDATA. rsp_valid_o is high the cycle after accept.
- reg_addr_o and reg_wdata_o hold their last value when idle. reg_we_o and reg_re_o are never high together and never high for two consecutive cycles.
- rsp_ready_i held high continuously: back-to-back transactions sustain 1 per 3 cycles (write) or 1 per 4 cycles (read).
- Reset mid-transaction: the transaction is dropped and no response is generated. Any strobe in flight is deasserted immediately (asynchronously).
- req_valid_i while not ready: ignored; the request is not latched.

Test Plan:
- Write addr 0x000 data 0x0000_0364 be F -> exactly one reg_we_o cycle with reg_addr_o=0x000, reg_wdata_o=0x364; rsp_valid 1 cycle later, err=0.
- Read addr 0x008 with the model returning 0x0000_00A5 the cycle after reg_re_o -> reg_re_o high exactly 1 cycle; rsp_rdata=0xA5 3 cycles after accept, err=0.
- Misaligned write addr 0x006, out-of-range read 0x020, and write be=4'h1 -> each gives rsp_err=1, rdata=0, and no reg_we_o/reg_re_o pulse ever.
- Hold rsp_ready_i=0 for 5 cycles after a read -> rsp_valid, rdata and err stable; req_ready_o=0; a new req_valid_i is not accepted until 1 cycle after the response handshake.
- Four back-to-back writes to 0x004 (0x11, 0x22, 0x33, 0x44) with rsp_ready=1 -> exactly 4 reg_we_o pulses in order, never adjacent, 4 error-free responses.
- Assert rst_ni=0 during RD -> reg_re_o drops immediately, no response is produced; after release, req_ready_o=1 one cycle later.
